// File: rtl/vga_timing_gen.sv
// Raster timing source: clk divider to a pixel strobe, h/v counters, registered syncs and a per-frame animate pulse.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/active by two pixel strobes to match a 2-stage colour pipeline.
module vga_timing_gen #(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_clk,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       animate
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_BEG     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_q, pix_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             active_q, active_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             animate_q, animate_d;

    // Syncs and active are decoded from the next-state counters so they land on the same edge as x/y.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_d = (div_d == DIV_LAST);
        x_d   = x_q;
        y_d   = y_q;
        if (pix_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        active_d  = (x_d < H_ACT) && (y_d < V_ACT);
        hsync_d   = ((x_d >= HS_BEG) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d   = ((y_d >= VS_BEG) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
        animate_d = pix_q && (x_q == H_LAST) && (y_q == V_ACT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            pix_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            active_q  <= 1'b1;
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            animate_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            pix_q     <= pix_d;
            x_q       <= x_d;
            y_q       <= y_d;
            active_q  <= active_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            animate_q <= animate_d;
        end
    end

    assign pix_clk = pix_q;
    assign x       = x_q;
    assign y       = y_q;
    assign animate = animate_q;

`ifdef VGA_SYNC_DELAY_EN
    logic [1:0] hs_dly_q, vs_dly_q, act_dly_q;

    // Stage 0 captures the pixel being left on this strobe, so stage 1 trails x,y by two pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_dly_q  <= {2{~SYNC_POL}};
            vs_dly_q  <= {2{~SYNC_POL}};
            act_dly_q <= 2'b00;
        end else if (pix_q) begin
            hs_dly_q  <= {hs_dly_q[0], hsync_q};
            vs_dly_q  <= {vs_dly_q[0], vsync_q};
            act_dly_q <= {act_dly_q[0], active_q};
        end
    end

    assign hsync  = hs_dly_q[1];
    assign vsync  = vs_dly_q[1];
    assign active = act_dly_q[1];
`else
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign active = active_q;
`endif

endmodule
